// File: rtl/window_classifier.sv
// rtl/window_classifier.sv - windowed majority vote over N_CLASS binarised neuron outputs.
// Define WINDOW_CLASSIFIER_HYST_EN to update To_Hex only when two consecutive windows agree.
module window_classifier #(
   parameter int                      N_CLASS  = 1,
   parameter int                      Z_W      = 32,
   parameter int                      WIN      = 42,
   parameter int                      VOTE_TH  = 20,
   parameter logic signed [Z_W-1:0]   THRESH   = '0,
   parameter logic [15:0]             HIT_CODE = 16'hFACE,
   localparam int                     CID_W    = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
   localparam int                     CNT_W    = $clog2(WIN + 1)
) (
   input  logic                       Clk,
   input  logic                       RST_n,
   input  logic [N_CLASS*Z_W-1:0]     Z,
   input  logic                       classify,
   input  logic                       clear,
   output logic [N_CLASS-1:0]         Hw,
   output logic                       result_valid,
   output logic [CID_W-1:0]           class_id,
   output logic [CNT_W-1:0]           win_count,
   output logic                       hit,
   output logic [15:0]                To_Hex
);

   localparam int               IDX_W    = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);
   localparam int               LEAVES   = 1 << CID_W;

   logic [N_CLASS-1:0] b;
   logic [CNT_W-1:0]   cnt_q [N_CLASS];
   logic [CNT_W-1:0]   tot_d [N_CLASS];
   logic [IDX_W-1:0]   idx_q;
   logic [N_CLASS-1:0] hw_q;
   logic               rv_q;
   logic [CID_W-1:0]   cid_q;
   logic [CNT_W-1:0]   wc_q;
   logic               hit_q;
   logic [15:0]        hex_q;

   logic [CNT_W-1:0]   node_cnt [2*LEAVES];
   logic [CID_W-1:0]   node_idx [2*LEAVES];
   logic [CID_W-1:0]   best_idx;
   logic [CNT_W-1:0]   best_cnt;
   logic               best_hit;
   logic [15:0]        best_hex;

`ifdef WINDOW_CLASSIFIER_HYST_EN
   logic               hist_hit_q;
   logic [CID_W-1:0]   hist_cid_q;
`endif

   // Totals include the current sample; the winner tree is a balanced heap
   // whose left child always holds the lower indices, so >= keeps ties low.
   always_comb begin
      for (int k = 0; k < N_CLASS; k++) begin
         b[k]     = $signed(Z[k*Z_W +: Z_W]) > THRESH;
         tot_d[k] = cnt_q[k] + CNT_W'(b[k]);
      end
      for (int n = 0; n < 2*LEAVES; n++) begin
         node_cnt[n] = '0;
         node_idx[n] = '0;
      end
      for (int k = 0; k < N_CLASS; k++) begin
         node_cnt[LEAVES+k] = tot_d[k];
         node_idx[LEAVES+k] = CID_W'(k);
      end
      for (int n = LEAVES - 1; n >= 1; n--) begin
         if (node_cnt[2*n] >= node_cnt[2*n+1]) begin
            node_cnt[n] = node_cnt[2*n];
            node_idx[n] = node_idx[2*n];
         end else begin
            node_cnt[n] = node_cnt[2*n+1];
            node_idx[n] = node_idx[2*n+1];
         end
      end
      best_idx = node_idx[1];
      best_cnt = node_cnt[1];
      best_hit = int'(best_cnt) > VOTE_TH;
      best_hex = best_hit ? (HIT_CODE + 16'(best_idx)) : 16'h0000;
   end

   always_ff @(posedge Clk or negedge RST_n) begin
      if (!RST_n) begin
         for (int k = 0; k < N_CLASS; k++) cnt_q[k] <= '0;
         idx_q <= '0;
         hw_q  <= '0;
         rv_q  <= 1'b0;
         cid_q <= '0;
         wc_q  <= '0;
         hit_q <= 1'b0;
         hex_q <= 16'h0000;
`ifdef WINDOW_CLASSIFIER_HYST_EN
         hist_hit_q <= 1'b0;
         hist_cid_q <= '0;
`endif
      end else begin
         rv_q <= 1'b0;
         if (clear) begin
            for (int k = 0; k < N_CLASS; k++) cnt_q[k] <= '0;
            idx_q <= '0;
`ifdef WINDOW_CLASSIFIER_HYST_EN
            hist_hit_q <= 1'b0;
            hist_cid_q <= '0;
`endif
         end else if (classify) begin
            hw_q <= b;
            if (idx_q == LAST_IDX) begin
               for (int k = 0; k < N_CLASS; k++) cnt_q[k] <= '0;
               idx_q <= '0;
               rv_q  <= 1'b1;
               cid_q <= best_idx;
               wc_q  <= best_cnt;
               hit_q <= best_hit;
`ifdef WINDOW_CLASSIFIER_HYST_EN
               if ({best_hit, best_idx} == {hist_hit_q, hist_cid_q}) hex_q <= best_hex;
               hist_hit_q <= best_hit;
               hist_cid_q <= best_idx;
`else
               hex_q <= best_hex;
`endif
            end else begin
               for (int k = 0; k < N_CLASS; k++) cnt_q[k] <= tot_d[k];
               idx_q <= idx_q + IDX_W'(1);
            end
         end
      end
   end

   assign Hw           = hw_q;
   assign result_valid = rv_q;
   assign class_id     = cid_q;
   assign win_count    = wc_q;
   assign hit          = hit_q;
   assign To_Hex       = hex_q;

endmodule

// File: tb/tb_window_classifier.sv
// tb/tb_window_classifier.sv - directed bench for window_classifier (1-class default and 4-class/WIN=8 instances).
`timescale 1ns/100ps
module tb_window_classifier;

`ifdef WINDOW_CLASSIFIER_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [31:0]  z1;
   logic         cls1, clr1;
   logic [0:0]   hw1;
   logic         rv1;
   logic [0:0]   cid1;
   logic [5:0]   wc1;
   logic         hit1;
   logic [15:0]  hex1;

   logic [127:0] z4;
   logic         cls4, clr4;
   logic [3:0]   hw4;
   logic         rv4;
   logic [1:0]   cid4;
   logic [3:0]   wc4;
   logic         hit4;
   logic [15:0]  hex4;

   int checks = 0;
   int errors = 0;

   window_classifier u_dut1 (
      .Clk(clk), .RST_n(rst_n), .Z(z1), .classify(cls1), .clear(clr1),
      .Hw(hw1), .result_valid(rv1), .class_id(cid1), .win_count(wc1),
      .hit(hit1), .To_Hex(hex1)
   );

   window_classifier #(.N_CLASS(4), .WIN(8), .VOTE_TH(4)) u_dut4 (
      .Clk(clk), .RST_n(rst_n), .Z(z4), .classify(cls4), .clear(clr4),
      .Hw(hw4), .result_valid(rv4), .class_id(cid4), .win_count(wc4),
      .hit(hit4), .To_Hex(hex4)
   );

   task automatic send1(input logic [31:0] z, input logic clr);
      z1 = z; cls1 = 1'b1; clr1 = clr;
      @(posedge clk); #1;
      cls1 = 1'b0; clr1 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; z1 = '0; cls1 = 0; clr1 = 0; z4 = '0; cls4 = 0; clr4 = 0;
      #12;
      checks++; if (hw1 !== 1'b0) begin errors++; $display("FAIL reset_hw: got %0d want 0", hw1); end
      checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_rv: got %0d want 0", rv1); end
      checks++; if (wc1 !== 6'd0) begin errors++; $display("FAIL reset_wc: got %0d want 0", wc1); end
      checks++; if (hit1 !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0d want 0", hit1); end
      checks++; if (hex1 !== 16'h0000) begin errors++; $display("FAIL reset_hex: got %h want 0000", hex1); end
      checks++; if (cid4 !== 2'd0 || hw4 !== 4'd0) begin errors++; $display("FAIL reset_dut4: got cid=%0d hw=%b want 0/0000", cid4, hw4); end
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_hit();
      int early = 0;
      for (int i = 0; i < 42; i++) begin
         send1((i < 21) ? 32'sd5 : -32'sd3, 1'b0);
         if (i == 0) begin
            checks++; if (hw1 !== 1'b1) begin errors++; $display("FAIL hit_hw_pos: got %0d want 1", hw1); end
         end
         if (i < 41 && rv1 === 1'b1) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL hit_early_rv: got %0d pulses want 0", early); end
      checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL hit_rv: got %0d want 1", rv1); end
      checks++; if (wc1 !== 6'd21) begin errors++; $display("FAIL hit_wc: got %0d want 21", wc1); end
      checks++; if (hit1 !== 1'b1) begin errors++; $display("FAIL hit_hit: got %0d want 1", hit1); end
      checks++; if (hw1 !== 1'b0) begin errors++; $display("FAIL hit_hw_neg: got %0d want 0", hw1); end
      checks++; if (hex1 !== (HYST ? 16'h0000 : 16'hFACE)) begin errors++; $display("FAIL hit_hex: got %h want %h", hex1, HYST ? 16'h0000 : 16'hFACE); end
      idle(1);
      checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL hit_rv_pulse: got %0d want 0", rv1); end
      checks++; if (wc1 !== 6'd21 || hit1 !== 1'b1) begin errors++; $display("FAIL hit_hold: got wc=%0d hit=%0d want 21/1", wc1, hit1); end
   endtask

   task automatic test_threshold();
      for (int i = 0; i < 42; i++) begin
         send1((i < 20) ? 32'sd5 : ((i == 20) ? 32'sd0 : -32'sd3), 1'b0);
         if (i == 20) begin
            checks++; if (hw1 !== 1'b0) begin errors++; $display("FAIL thr_hw_zero: got %0d want 0", hw1); end
         end
      end
      checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL thr_rv: got %0d want 1", rv1); end
      checks++; if (wc1 !== 6'd20) begin errors++; $display("FAIL thr_wc: got %0d want 20", wc1); end
      checks++; if (hit1 !== 1'b0) begin errors++; $display("FAIL thr_hit: got %0d want 0", hit1); end
      checks++; if (hex1 !== 16'h0000) begin errors++; $display("FAIL thr_hex: got %h want 0000", hex1); end
   endtask

   task automatic send4_window(input bit all_neg);
      for (int i = 0; i < 8; i++) begin
         z4[0  +: 32] = (!all_neg && i == 0) ? 32'sd1 : -32'sd1;
         z4[32 +: 32] = (!all_neg && i == 1) ? 32'sd1 : -32'sd1;
         z4[64 +: 32] = (!all_neg && i >= 2) ? 32'sd1 : -32'sd1;
         z4[96 +: 32] = (!all_neg && i < 6) ? 32'sd1 : -32'sd1;
         cls4 = 1'b1;
         @(posedge clk); #1;
      end
      cls4 = 1'b0;
   endtask

   task automatic test_multiclass();
      send4_window(1'b0);
      checks++; if (rv4 !== 1'b1) begin errors++; $display("FAIL mc_rv: got %0d want 1", rv4); end
      checks++; if (cid4 !== 2'd2) begin errors++; $display("FAIL mc_cid: got %0d want 2", cid4); end
      checks++; if (wc4 !== 4'd6) begin errors++; $display("FAIL mc_wc: got %0d want 6", wc4); end
      checks++; if (hit4 !== 1'b1) begin errors++; $display("FAIL mc_hit: got %0d want 1", hit4); end
      checks++; if (hw4 !== 4'b0100) begin errors++; $display("FAIL mc_hw: got %b want 0100", hw4); end
      send4_window(1'b0);
      checks++; if (cid4 !== 2'd2 || hex4 !== 16'hFAD0) begin errors++; $display("FAIL mc_hex: got cid=%0d hex=%h want 2/FAD0", cid4, hex4); end
      send4_window(1'b1);
      checks++; if (cid4 !== 2'd0 || wc4 !== 4'd0 || hit4 !== 1'b0) begin errors++; $display("FAIL mc_zero: got cid=%0d wc=%0d hit=%0d want 0/0/0", cid4, wc4, hit4); end
      checks++; if (hex4 !== (HYST ? 16'hFAD0 : 16'h0000)) begin errors++; $display("FAIL mc_zero_hex: got %h want %h", hex4, HYST ? 16'hFAD0 : 16'h0000); end
   endtask

   task automatic test_clear();
      int early = 0;
      for (int i = 0; i < 30; i++) send1(32'sd5, 1'b0);
      send1(-32'sd3, 1'b1);
      checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL clr_rv: got %0d want 0", rv1); end
      checks++; if (hw1 !== 1'b1) begin errors++; $display("FAIL clr_hw_held: got %0d want 1", hw1); end
      for (int i = 0; i < 42; i++) begin
         send1(32'sd5, 1'b0);
         if (i < 41 && rv1 === 1'b1) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL clr_early_rv: got %0d pulses want 0", early); end
      checks++; if (rv1 !== 1'b1 || wc1 !== 6'd42) begin errors++; $display("FAIL clr_close: got rv=%0d wc=%0d want 1/42", rv1, wc1); end
      checks++; if (hex1 !== (HYST ? 16'h0000 : 16'hFACE)) begin errors++; $display("FAIL clr_hex: got %h want %h", hex1, HYST ? 16'h0000 : 16'hFACE); end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      for (int i = 0; i < 84; i++) begin
         send1((i < 42 || i < 67) ? 32'sd5 : -32'sd3, 1'b0);
         if (rv1 === 1'b1) pulses++;
         if (i == 41) begin
            checks++; if (rv1 !== 1'b1 || wc1 !== 6'd42 || hex1 !== 16'hFACE) begin errors++; $display("FAIL b2b_w1: got rv=%0d wc=%0d hex=%h want 1/42/FACE", rv1, wc1, hex1); end
         end
      end
      checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
      checks++; if (rv1 !== 1'b1 || wc1 !== 6'd25 || hit1 !== 1'b1) begin errors++; $display("FAIL b2b_w2: got rv=%0d wc=%0d hit=%0d want 1/25/1", rv1, wc1, hit1); end
   endtask

   task automatic test_reset_mid();
      int early = 0;
      for (int i = 0; i < 10; i++) send1(32'sd5, 1'b0);
      #2;
      rst_n = 1'b0;
      #0.5;
      checks++; if (hw1 !== 1'b0 || wc1 !== 6'd0 || hit1 !== 1'b0 || hex1 !== 16'h0000 || rv1 !== 1'b0) begin
         errors++; $display("FAIL rstmid_outputs: got hw=%0d wc=%0d hit=%0d hex=%h rv=%0d want all 0", hw1, wc1, hit1, hex1, rv1);
      end
      #0.5;
      rst_n = 1'b1;
      for (int i = 0; i < 42; i++) begin
         send1((i < 21) ? 32'sd5 : -32'sd3, 1'b0);
         if (i < 41 && rv1 === 1'b1) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL rstmid_early_rv: got %0d pulses want 0", early); end
      checks++; if (rv1 !== 1'b1 || wc1 !== 6'd21) begin errors++; $display("FAIL rstmid_close: got rv=%0d wc=%0d want 1/21", rv1, wc1); end
      checks++; if (hex1 !== (HYST ? 16'h0000 : 16'hFACE)) begin errors++; $display("FAIL rstmid_hex: got %h want %h", hex1, HYST ? 16'h0000 : 16'hFACE); end
   endtask

   task automatic test_hyst();
      clr1 = 1'b1;
      idle(1);
      clr1 = 1'b0;
      for (int i = 0; i < 42; i++) send1(32'sd5, 1'b0);
      checks++; if (hex1 !== (HYST ? 16'h0000 : 16'hFACE)) begin errors++; $display("FAIL hyst_a: got %h want %h", hex1, HYST ? 16'h0000 : 16'hFACE); end
      for (int i = 0; i < 42; i++) send1(32'sd5, 1'b0);
      checks++; if (hex1 !== 16'hFACE) begin errors++; $display("FAIL hyst_b: got %h want FACE", hex1); end
      for (int i = 0; i < 42; i++) send1(-32'sd3, 1'b0);
      checks++; if (hit1 !== 1'b0 || rv1 !== 1'b1) begin errors++; $display("FAIL hyst_c_raw: got hit=%0d rv=%0d want 0/1", hit1, rv1); end
      checks++; if (hex1 !== (HYST ? 16'hFACE : 16'h0000)) begin errors++; $display("FAIL hyst_c: got %h want %h", hex1, HYST ? 16'hFACE : 16'h0000); end
   endtask

   initial begin
      test_reset();
      test_hit();
      test_threshold();
      test_multiclass();
      test_clear();
      test_back_to_back();
      test_reset_mid();
      test_hyst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
